// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer: default step counts, bus
// addresses and the reset-delay FSM encoding.
package apu_pkg;

  localparam int unsigned APU_CNT_W = 16;
  localparam int unsigned APU_STEP1 = 7457;
  localparam int unsigned APU_STEP2 = 14913;
  localparam int unsigned APU_STEP3 = 22371;
  localparam int unsigned APU_STEP4 = 29829;
  localparam int unsigned APU_STEP5 = 37281;

  localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
  localparam logic [15:0] APU_FRAME_ADDR  = 16'h4017;

  localparam int unsigned     DLY_W    = 3;
  localparam logic [DLY_W-1:0] DLY_EVEN = 3'd3;
  localparam logic [DLY_W-1:0] DLY_ODD  = 3'd4;

  typedef enum logic {
    RUN      = 1'b0,
    RST_WAIT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/apu_frame_irq.sv
// APU frame sequencer: 4/5-step counter, $4017 write with delayed counter
// reset, frame IRQ flag readable at $4015, and quarter/half-frame strobes.
module apu_frame_irq
  import apu_pkg::*;
#(
  parameter int unsigned CNT_W = APU_CNT_W,
  parameter int unsigned STEP1 = APU_STEP1,
  parameter int unsigned STEP2 = APU_STEP2,
  parameter int unsigned STEP3 = APU_STEP3,
  parameter int unsigned STEP4 = APU_STEP4,
  parameter int unsigned STEP5 = APU_STEP5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_out,
  output logic        nIRQ,
  output logic        quarter_frame,
  output logic        half_frame
);

  localparam logic [CNT_W-1:0] S1     = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2     = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3     = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4     = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5     = CNT_W'(STEP5);
  localparam logic [CNT_W-1:0] S4_LO  = CNT_W'(STEP4 - 1);
  localparam logic [CNT_W-1:0] S4_END = CNT_W'(STEP4 + 1);
  localparam logic [CNT_W-1:0] S5_END = CNT_W'(STEP5 + 1);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             flag_q, flag_d;
  logic             parity_q, parity_d;
  logic             nirq_q, nirq_d;

  logic frame_wr, status_rd, expire, wrap, irq_set;
  logic last_step, step_q, step_h;
  logic unused_data;

  always_comb begin
    frame_wr    = !halt && cpu_write_en && (cpu_addr == APU_FRAME_ADDR);
    status_rd   = !halt && cpu_read_en && (cpu_addr == APU_STATUS_ADDR);
    last_step   = mode_q ? (cnt_q == S5) : (cnt_q == S4);
    step_q      = (cnt_q == S1) || (cnt_q == S2) || (cnt_q == S3) || last_step;
    step_h      = (cnt_q == S2) || last_step;
    wrap        = mode_q ? (cnt_q == S5_END) : (cnt_q == S4_END);
    irq_set     = !mode_q && !inhibit_q && (cnt_q >= S4_LO) && (cnt_q <= S4_END);
    // A write landing on the expiry cycle restarts the delay instead of firing.
    expire      = (state_q == RST_WAIT) && (dly_q == DLY_W'(1)) && !frame_wr;
    unused_data = ^cpu_data_in[5:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    flag_d    = flag_q;
    parity_d  = parity_q;

    if (!halt) begin
      parity_d = ~parity_q;
      cnt_d    = (expire || wrap) ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
        RUN: begin
          if (frame_wr) begin
            state_d = RST_WAIT;
            dly_d   = parity_q ? DLY_ODD : DLY_EVEN;
          end
        end
        RST_WAIT: begin
          if (frame_wr) begin
            dly_d = parity_q ? DLY_ODD : DLY_EVEN;
          end else if (expire) begin
            state_d = RUN;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
        default: state_d = RUN;
      endcase

      if (frame_wr) begin
        mode_d    = cpu_data_in[7];
        inhibit_d = cpu_data_in[6];
      end

      // Inhibit write beats a set; a set beats a status-read clear.
      if (frame_wr && cpu_data_in[6]) begin
        flag_d = 1'b0;
      end else if (irq_set) begin
        flag_d = 1'b1;
      end else if (status_rd) begin
        flag_d = 1'b0;
      end
    end

    nirq_d = ~flag_d;
  end

  always_comb begin
    quarter_frame = !halt && (step_q || (expire && mode_q));
    half_frame    = !halt && (step_h || (expire && mode_q));
    cpu_data_out  = status_rd ? {1'b0, flag_q, 6'b0} : '0;
    nIRQ          = nirq_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      dly_q     <= '0;
      mode_q    <= 1'b0;
      inhibit_q <= 1'b0;
      flag_q    <= 1'b0;
      parity_q  <= 1'b0;
      nirq_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      flag_q    <= flag_d;
      parity_q  <= parity_d;
      nirq_q    <= nirq_d;
    end
  end

endmodule

// File: tb/tb_apu_frame_irq.sv
// Scoreboard bench for apu_frame_irq: a full-size instance and a short-step
// instance, each shadowed by a cycle model that predicts every output.
module tb_apu_frame_irq;

  typedef struct packed {
    logic        halt;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  d;
  } in_t;

  typedef struct {
    int cnt;
    bit mode;
    bit inh;
    bit flag;
    bit par;
    bit wt;
    int dly;
  } mdl_t;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  localparam int ST [2][5] = '{'{7457, 14913, 22371, 29829, 37281},
                               '{10, 20, 30, 40, 50}};
  localparam in_t IDLE = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  in_t  in0 = '0;
  in_t  in1 = '0;
  logic [7:0] dout0, dout1;
  logic nirq0, nirq1, qf0, qf1, hf0, hf1;

  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apu_frame_irq u_dut0 (
    .clk(clk), .rst(rst), .halt(in0.halt), .cpu_addr(in0.addr),
    .cpu_data_in(in0.d), .cpu_write_en(in0.wr), .cpu_read_en(in0.rd),
    .cpu_data_out(dout0), .nIRQ(nirq0), .quarter_frame(qf0), .half_frame(hf0)
  );

  apu_frame_irq #(
    .CNT_W(8), .STEP1(10), .STEP2(20), .STEP3(30), .STEP4(40), .STEP5(50)
  ) u_dut1 (
    .clk(clk), .rst(rst), .halt(in1.halt), .cpu_addr(in1.addr),
    .cpu_data_in(in1.d), .cpu_write_en(in1.wr), .cpu_read_en(in1.rd),
    .cpu_data_out(dout1), .nIRQ(nirq1), .quarter_frame(qf1), .half_frame(hf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.cnt = 0; m.mode = 0; m.inh = 0; m.flag = 0; m.par = 0; m.wt = 0; m.dly = 0;
    return m;
  endfunction

  // Expected {nIRQ, quarter, half, data_out} for the cycle the stimulus is applied.
  function automatic logic [10:0] predict(input mdl_t m, input in_t i, input int k);
    int  last;
    bit  act, fw, sr, pulse, q, h;
    logic [7:0] d;
    act   = !i.halt;
    fw    = act && i.wr && (i.addr == 16'h4017);
    sr    = act && i.rd && (i.addr == 16'h4015);
    last  = m.mode ? ST[k][4] : ST[k][3];
    pulse = m.wt && (m.dly == 1) && !fw && m.mode;
    q = act && (m.cnt == ST[k][0] || m.cnt == ST[k][1] || m.cnt == ST[k][2] ||
                m.cnt == last || pulse);
    h = act && (m.cnt == ST[k][1] || m.cnt == last || pulse);
    d = (sr && m.flag) ? 8'h40 : 8'h00;
    return {!m.flag, q, h, d};
  endfunction

  function automatic mdl_t advance(input mdl_t m, input in_t i, input int k);
    mdl_t n;
    bit   fw, sr, expire, setc;
    int   endc;
    n = m;
    if (i.halt) return n;
    fw     = i.wr && (i.addr == 16'h4017);
    sr     = i.rd && (i.addr == 16'h4015);
    expire = m.wt && (m.dly == 1) && !fw;
    endc   = (m.mode ? ST[k][4] : ST[k][3]) + 1;
    setc   = !m.mode && !m.inh && (m.cnt >= ST[k][3] - 1) && (m.cnt <= ST[k][3] + 1);
    n.par  = !m.par;
    n.cnt  = (expire || m.cnt == endc) ? 0 : m.cnt + 1;
    if (fw) begin
      n.mode = i.d[7];
      n.inh  = i.d[6];
      n.wt   = 1;
      n.dly  = m.par ? 4 : 3;
    end else if (expire) begin
      n.wt = 0;
    end else if (m.wt) begin
      n.dly = m.dly - 1;
    end
    if (fw && i.d[6])  n.flag = 0;
    else if (setc)     n.flag = 1;
    else if (sr)       n.flag = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 <= mdl_reset();
      m1 <= mdl_reset();
    end else begin
      m0 <= advance(m0, in0, 0);
      m1 <= advance(m1, in1, 1);
    end
  end

  always @(negedge clk) begin
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      check_eq(e0.tag, 32'({nirq0, qf0, hf0, dout0}), 32'(e0.v));
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check_eq(e1.tag, 32'({nirq1, qf1, hf1, dout1}), 32'(e1.v));
    end
  end

  function automatic in_t mk(input bit h, input bit w, input bit r,
                             input logic [15:0] a, input logic [7:0] d);
    in_t s;
    s.halt = h; s.wr = w; s.rd = r; s.addr = a; s.d = d;
    return s;
  endfunction

  // Drive one cycle on the selected instance (the other idles) and queue predictions.
  task automatic tick(input int sel, input in_t s, input string tag);
    exp_t e;
    in0 = (sel == 0) ? s : IDLE;
    in1 = (sel == 1) ? s : IDLE;
    e.tag = {"d0:", (sel == 0) ? tag : "bg"};
    e.v   = predict(m0, in0, 0);
    q0.push_back(e);
    e.tag = {"d1:", (sel == 1) ? tag : "bg"};
    e.v   = predict(m1, in1, 1);
    q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int sel, input int target, input int max);
    int n = 0;
    while (((sel == 0) ? m0.cnt : m1.cnt) != target && n < max) begin
      tick(sel, IDLE, "run");
      n++;
    end
    check_eq("reach_cnt", 32'((sel == 0) ? m0.cnt : m1.cnt), 32'(target));
  endtask

  task automatic run_par(input int sel, input bit p);
    int n = 0;
    while (((sel == 0) ? m0.par : m1.par) != p && n < 4) begin
      tick(sel, IDLE, "par");
      n++;
    end
  endtask

  task automatic wait_flag1();
    int n = 0;
    while (!m1.flag && n < 200) begin
      tick(1, IDLE, "to_flag");
      n++;
    end
    check_eq("reach_flag", 32'(m1.flag), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    repeat (3) tick(0, IDLE, "rst");
    check_eq("rst_out0", 32'({nirq0, qf0, hf0, dout0}), 32'h400);
    check_eq("rst_out1", 32'({nirq1, qf1, hf1, dout1}), 32'h400);
    rst = 1'b1;

    // Full-size instance: mode-0 frame with a halt window, reads around the IRQ window.
    run_until(0, 7000, 8000);
    tick(0, mk(1, 1, 0, 16'h4017, 8'h40), "halt_wr");
    repeat (999) tick(0, mk(1, 0, 0, 16'h0000, 8'h00), "halt");
    run_until(0, 7457, 600);
    tick(0, IDLE, "step1");
    run_until(0, 29828, 23000);
    tick(0, IDLE, "irq_set");
    tick(0, mk(0, 0, 1, 16'h4015, 8'h00), "rd_set_wins");
    tick(0, mk(0, 0, 1, 16'h4015, 8'h00), "rd_set_end");
    run_until(0, 3, 10);
    tick(0, mk(0, 0, 1, 16'h4015, 8'h00), "rd_clear");
    tick(0, IDLE, "rd_nirq_rel");

    // Switch to 5-step with even parity, then one whole 5-step frame.
    run_par(0, 1'b0);
    tick(0, mk(0, 1, 0, 16'h4017, 8'h80), "wr80_p0");
    repeat (3) tick(0, IDLE, "wr80_p0_wait");
    run_until(0, 37281, 38000);
    tick(0, IDLE, "step5");
    run_until(0, 0, 10);
    repeat (4) tick(0, IDLE, "m1_wrap");

    // Short-step instance: inhibit write clears a pending IRQ, then two silent frames.
    run_until(1, 41, 100);
    tick(1, mk(0, 1, 0, 16'h4017, 8'h40), "wr40_clr");
    tick(1, IDLE, "wr40_nirq");
    repeat (100) tick(1, IDLE, "inh_frames");

    // 5-step write on odd parity, one frame of 5-step running.
    run_par(1, 1'b1);
    tick(1, mk(0, 1, 0, 16'h4017, 8'h80), "wr80_p1");
    repeat (4) tick(1, IDLE, "wr80_p1_wait");
    repeat (60) tick(1, IDLE, "m1_frame");

    // Second write inside the delay reloads it.
    run_par(1, 1'b0);
    tick(1, mk(0, 1, 0, 16'h4017, 8'hC0), "reload_a");
    tick(1, IDLE, "reload_gap");
    tick(1, mk(0, 1, 0, 16'h4017, 8'h80), "reload_b");
    repeat (6) tick(1, IDLE, "reload_wait");

    // Back to 4-step, get the flag, then reset in the middle of the delay.
    tick(1, mk(0, 1, 0, 16'h4017, 8'h00), "wr00");
    wait_flag1();
    tick(1, mk(0, 1, 0, 16'h4017, 8'h00), "wr_flag_set");
    tick(1, IDLE, "rst_wait_mid");
    rst = 1'b0;
    #1;
    repeat (2) tick(1, IDLE, "rst_mid");
    check_eq("rst_mid_out1", 32'({nirq1, qf1, hf1, dout1}), 32'h400);
    rst = 1'b1;
    repeat (8) tick(1, IDLE, "post_rst");

    // Foreign addresses and the flag-clear read with nothing pending.
    tick(1, mk(0, 0, 1, 16'h4016, 8'h00), "rd_other");
    tick(1, mk(0, 1, 0, 16'h4015, 8'hC0), "wr_other");
    tick(1, mk(0, 0, 1, 16'h4015, 8'h00), "rd_noflag");
    repeat (50) tick(1, IDLE, "tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
